// File: rtl/sparrow_mem_if.sv
// Request/response bundle between sparrow_mem and its two clients
// (instruction fetch and load/store), plus the sticky-fault reporting signals.
interface sparrow_mem_if;
  logic        instr_mem_req_i;
  logic [31:0] instr_mem_addr_i;
  logic [31:0] mem_rd_data_o;
  logic        mem_rd_valid_o;

  logic        data_mem_req_i;
  logic        data_mem_we_i;
  logic [3:0]  data_mem_be_i;
  logic [31:0] data_mem_addr_i;
  logic [31:0] data_mem_wr_data_i;
  logic [31:0] data_mem_rd_data_o;
  logic        data_mem_rd_valid_o;

  logic        mem_fault_o;
  logic [31:0] mem_fault_addr_o;
  logic        mem_fault_src_o;
  logic        mem_fault_clr_i;

  modport slave (
    input  instr_mem_req_i, instr_mem_addr_i,
    input  data_mem_req_i, data_mem_we_i, data_mem_be_i, data_mem_addr_i, data_mem_wr_data_i,
    input  mem_fault_clr_i,
    output mem_rd_data_o, mem_rd_valid_o,
    output data_mem_rd_data_o, data_mem_rd_valid_o,
    output mem_fault_o, mem_fault_addr_o, mem_fault_src_o
  );

  modport master (
    output instr_mem_req_i, instr_mem_addr_i,
    output data_mem_req_i, data_mem_we_i, data_mem_be_i, data_mem_addr_i, data_mem_wr_data_i,
    output mem_fault_clr_i,
    input  mem_rd_data_o, mem_rd_valid_o,
    input  data_mem_rd_data_o, data_mem_rd_valid_o,
    input  mem_fault_o, mem_fault_addr_o, mem_fault_src_o
  );
endinterface

// File: rtl/sparrow_mem.sv
// Word-organised memory with a read-only instruction port and a byte-masked data port,
// one-cycle read latency, bounds/alignment checking and a sticky first-fault record.
module sparrow_mem #(
  parameter int DEPTH_WORDS = 4096
) (
  input logic           clk,
  input logic           reset_n,
  sparrow_mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] instr_idx;
  logic [AW-1:0] data_idx;
  logic          instr_legal;
  logic          data_legal;
  logic          instr_fault;
  logic          data_fault;
  logic          data_wr_en;
  logic          fault_capture;

  logic [31:0]   instr_rd_data;
  logic          instr_rd_valid;
  logic [31:0]   data_rd_data;
  logic          data_rd_valid;
  logic          fault_flag;
  logic [31:0]   fault_addr;
  logic          fault_src;

  assign instr_idx   = bus.instr_mem_addr_i[AW+1:2];
  assign data_idx    = bus.data_mem_addr_i[AW+1:2];
  assign instr_legal = (bus.instr_mem_addr_i[1:0] == 2'b00) &&
                       (bus.instr_mem_addr_i[31:AW+2] == '0);
  assign data_legal  = (bus.data_mem_addr_i[1:0] == 2'b00) &&
                       (bus.data_mem_addr_i[31:AW+2] == '0);

  assign instr_fault   = bus.instr_mem_req_i && !instr_legal;
  assign data_fault    = bus.data_mem_req_i && !data_legal;
  assign data_wr_en    = reset_n && bus.data_mem_req_i && bus.data_mem_we_i && data_legal;
  assign fault_capture = !fault_flag || bus.mem_fault_clr_i;

  // Nonblocking update gives read-before-write on same-word collisions.
  always_ff @(posedge clk) begin
    if (data_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.data_mem_be_i[k]) begin
          mem[data_idx][8*k +: 8] <= bus.data_mem_wr_data_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_rd_data  <= '0;
      instr_rd_valid <= 1'b0;
    end else begin
      instr_rd_valid <= bus.instr_mem_req_i;
      if (bus.instr_mem_req_i) begin
        instr_rd_data <= instr_legal ? mem[instr_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_rd_data  <= '0;
      data_rd_valid <= 1'b0;
    end else begin
      data_rd_valid <= bus.data_mem_req_i && !bus.data_mem_we_i;
      if (bus.data_mem_req_i && !bus.data_mem_we_i) begin
        data_rd_data <= data_legal ? mem[data_idx] : '0;
      end
    end
  end

  // A clear in the same cycle as a new fault still records the new fault.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault_flag <= 1'b0;
      fault_addr <= '0;
      fault_src  <= 1'b0;
    end else if (fault_capture) begin
      if (instr_fault) begin
        fault_flag <= 1'b1;
        fault_addr <= bus.instr_mem_addr_i;
        fault_src  <= 1'b0;
      end else if (data_fault) begin
        fault_flag <= 1'b1;
        fault_addr <= bus.data_mem_addr_i;
        fault_src  <= 1'b1;
      end else if (bus.mem_fault_clr_i) begin
        fault_flag <= 1'b0;
      end
    end
  end

  assign bus.mem_rd_data_o       = instr_rd_data;
  assign bus.mem_rd_valid_o      = instr_rd_valid;
  assign bus.data_mem_rd_data_o  = data_rd_data;
  assign bus.data_mem_rd_valid_o = data_rd_valid;
  assign bus.mem_fault_o         = fault_flag;
  assign bus.mem_fault_addr_o    = fault_addr;
  assign bus.mem_fault_src_o     = fault_src;
endmodule
